dcache_responder: RTL and testbench
===================================

Name: dcache_responder

Overview:
- Memory-side responder for the core's data-memory request port: accepts load/store requests, returns read data, and drives `stall`.
- Direct-mapped, write-through, write-no-allocate data cache.
- Sits between the CPU data port and the main-memory request/response interface.
- Load misses fetch one 128-bit line; every store is written through to memory.

Parameters:
- LINES, 64, number of cache lines (power of 2); each line is 4 words (128 bits).
- TAG_W, 4, width of mem_req_tag / mem_resp_tag.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- cpu_req_addr  input  32  byte address; bits [1:0] are ignored.
- cpu_req_re  input  1  load request.
- cpu_req_we  input  4  byte write enables; nonzero = store.
- cpu_req_din  input  32  store data, already lane-aligned.
- cpu_resp_dout  output  32  load data.
- stall  output  1  responder busy; CPU must freeze and ignore dout.
- mem_req_valid  output  1  command valid.
- mem_req_ready  input  1  command accepted.
- mem_req_rw  output  1  1 = write, 0 = read.
- mem_req_addr  output  28  line address (byte address [31:4]).
- mem_req_tag  output  TAG_W  transaction tag.
- mem_req_data_valid  output  1  write data valid.
- mem_req_data_ready  input  1  write data accepted.
- mem_req_data_bits  output  128  write data.
- mem_req_data_mask  output  16  byte mask.
- mem_resp_valid  input  1  read response valid.
- mem_resp_data  input  128  line data.
- mem_resp_tag  input  TAG_W  response tag.

Behaviour:
- Address split: offset [3:2], index [log2(LINES)+3:4], tag = remaining upper bits.
- Storage: data array, tag array, and valid bit per line.
- Request capture: a request is sampled at a clock edge when `stall` is 0 and (`re` or `we` is nonzero). Its address, re, we and din are registered.
- If both re and we are nonzero, the request is a store.
- Tag compare (LOOKUP) uses the registered request.
- FSM states: IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_REQ.
- IDLE → LOOKUP on request capture.
- LOOKUP, load hit:
  - cpu_resp_dout = selected word this cycle; stall = 0.
  - May capture the next request in the same cycle (back-to-back hits sustain 1 per cycle, 1-cycle load latency).
  - → LOOKUP on a new request, otherwise → IDLE.
- LOOKUP, load miss: stall = 1 (combinational in this cycle); → RD_REQ.
- LOOKUP, store: stall = 1.
  - On a hit, the cached word is byte-merged with we at the end of this cycle.
  - → WR_REQ.
- RD_REQ: mem_req_valid = 1, rw = 0, addr = line, tag = tag counter. Hold until mem_req_ready; then → RD_WAIT.
- RD_WAIT: wait for mem_resp_valid with mem_resp_tag equal to the issued tag.
  - Responses with other tags are ignored.
  - On a match: write the line, tag and valid = 1; cpu_resp_dout = requested word of mem_resp_data in the following cycle, with stall = 0 in that cycle; → IDLE.
- WR_REQ: mem_req_valid and mem_req_data_valid are asserted together.
  - rw = 1; data_bits = din replicated ×4; mask = we << (4*offset).
  - Each valid drops independently after its own handshake, in any order.
  - When both are done: stall = 0 in the next cycle; → IDLE.
- Store miss: no allocate; the array is unchanged.
- Tag counter: increments (mod 2^TAG_W) after each accepted read command.
- stall: 1 in every cycle the FSM is in LOOKUP with a miss or store, in RD_REQ, RD_WAIT or WR_REQ, and in all cycles between; 0 otherwise.
- cpu_resp_dout is valid only in the cycle stall falls or in a hit cycle; otherwise don't-care (drive 0).
- Reset (also mid-transaction):
  - All valid bits = 0; FSM = IDLE; stall = 0; mem_req_valid = 0; mem_req_data_valid = 0; tag counter = 0; cpu_resp_dout = 0.
  - Any outstanding memory response arriving after reset is ignored.
- Address 0 and the top line index wrap with no special case.

Test Plan:
- After reset, load 0x0000_1004 (miss) → RD_REQ addr 0x0000100, tag 0; stall held; resp data 0x…_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA tag 0 → dout = 0xBBBBBBBB, stall falls the next cycle.
- Repeat the load to 0x1004, then a load to 0x1008 back-to-back → both hit, stall stays 0, dout = 0xBBBBBBBB then 0xCCCCCCCC on consecutive cycles, no mem_req_valid.
- Store we = 4'b0011, din 0x0000_1234, to 0x1008 (hit) → mem_req addr 0x0000100, mask 16'h0300, data = din×4; a following load of 0x1008 returns 0xCCCC1234.
- Store to uncached 0x2000 → write issued with mask 16'h000F; a following load of 0x2000 misses (no allocate).
- Delay mem_req_data_ready 3 cycles after mem_req_ready → stall held until both handshakes are done; a response carrying a stale tag during RD_WAIT is ignored.
- Assert reset during RD_WAIT → stall 0 and mem valids 0 the next cycle; the late response is ignored; re-loading 0x1004 misses.

Source files
------------

// File: rtl/dcache_responder_if.sv
// CPU data-port and main-memory command/response signals of the data-cache responder.
// slave = the responder itself, master = the CPU plus memory environment around it.
interface dcache_responder_if #(
   parameter int TAG_W = 4
);
   logic [31:0]      cpu_req_addr;
   logic             cpu_req_re;
   logic [3:0]       cpu_req_we;
   logic [31:0]      cpu_req_din;
   logic [31:0]      cpu_resp_dout;
   logic             stall;
   // Memory channels: a transfer happens in a cycle where valid and ready are both 1;
   // valid never drops before its transfer, ready may toggle freely.
   logic             mem_req_valid;
   logic             mem_req_ready;
   logic             mem_req_rw;
   logic [27:0]      mem_req_addr;
   logic [TAG_W-1:0] mem_req_tag;
   logic             mem_req_data_valid;
   logic             mem_req_data_ready;
   logic [127:0]     mem_req_data_bits;
   logic [15:0]      mem_req_data_mask;
   logic             mem_resp_valid;
   logic [127:0]     mem_resp_data;
   logic [TAG_W-1:0] mem_resp_tag;

   modport slave (
      input  cpu_req_addr, cpu_req_re, cpu_req_we, cpu_req_din,
      input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data, mem_resp_tag,
      output cpu_resp_dout, stall,
      output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
      output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask
   );

   modport master (
      output cpu_req_addr, cpu_req_re, cpu_req_we, cpu_req_din,
      output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data, mem_resp_tag,
      input  cpu_resp_dout, stall,
      input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
      input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask
   );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, write-no-allocate data cache with 4-word lines.
// Load hits answer in the cycle after capture; misses fetch a line, every store writes through.
module dcache_responder #(
   parameter int LINES = 64,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   dcache_responder_if.slave  bus,
   output logic [2:0]         state_o
);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAGB_W = 28 - IDX_W;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_RD_REQ, S_RD_WAIT, S_WR_REQ} state_e;

   state_e             state_q, state_d;
   logic [127:0]       data_q [LINES];
   logic [TAGB_W-1:0]  tag_q [LINES];
   logic [LINES-1:0]   valid_q;
   logic [29:0]        addr_q;
   logic               re_q;
   logic [3:0]         we_q;
   logic [31:0]        din_q;
   logic [TAG_W-1:0]   tag_cnt_q;
   logic               cmd_done_q, data_done_q;
   logic               resp_pend_q;
   logic [31:0]        resp_word_q;

   logic [1:0]         offset;
   logic [IDX_W-1:0]   idx;
   logic [TAGB_W-1:0]  rtag;
   logic [127:0]       cur_line, merged_line;
   logic               is_store, is_load, hit, cap;
   logic               req_valid, data_valid, cmd_fire, data_fire, cmd_ok, data_ok;
   logic               resp_match, rd_fill, st_merge;
   logic               unused_addr_bits;

   assign offset   = addr_q[1:0];
   assign idx      = addr_q[IDX_W+1:2];
   assign rtag     = addr_q[29:IDX_W+2];
   assign is_store = (we_q != 4'b0000);
   assign is_load  = re_q && !is_store;
   assign cur_line = data_q[idx];
   assign hit      = valid_q[idx] && (tag_q[idx] == rtag);

   assign cmd_fire   = req_valid && bus.mem_req_ready;
   assign data_fire  = data_valid && bus.mem_req_data_ready;
   assign cmd_ok     = cmd_done_q || cmd_fire;
   assign data_ok    = data_done_q || data_fire;
   // Counter was bumped when the read command was accepted, so the issued tag is one behind.
   assign resp_match = bus.mem_resp_valid && (bus.mem_resp_tag == (tag_cnt_q - TAG_W'(1)));
   assign rd_fill    = (state_q == S_RD_WAIT) && resp_match;
   assign st_merge   = (state_q == S_LOOKUP) && is_store && hit;
   assign cap        = !bus.stall && (bus.cpu_req_re || (bus.cpu_req_we != 4'b0000));

   assign unused_addr_bits = ^bus.cpu_req_addr[1:0];

   always_comb begin
      merged_line = cur_line;
      for (int b = 0; b < 4; b++) begin
         if (we_q[b]) merged_line[{offset, 5'b0} + 7'(b * 8) +: 8] = din_q[b*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         valid_q     <= '0;
         addr_q      <= '0;
         re_q        <= 1'b0;
         we_q        <= 4'b0000;
         din_q       <= '0;
         tag_cnt_q   <= '0;
         cmd_done_q  <= 1'b0;
         data_done_q <= 1'b0;
         resp_pend_q <= 1'b0;
         resp_word_q <= '0;
      end else begin
         state_q     <= state_d;
         resp_pend_q <= rd_fill;
         if (cap) begin
            addr_q <= bus.cpu_req_addr[31:2];
            re_q   <= bus.cpu_req_re;
            we_q   <= bus.cpu_req_we;
            din_q  <= bus.cpu_req_din;
         end
         if ((state_q == S_RD_REQ) && cmd_fire) tag_cnt_q <= tag_cnt_q + TAG_W'(1);
         if (rd_fill) begin
            valid_q[idx] <= 1'b1;
            resp_word_q  <= bus.mem_resp_data[{offset, 5'b0} +: 32];
         end
         if ((state_q == S_WR_REQ) && !(cmd_ok && data_ok)) begin
            cmd_done_q  <= cmd_ok;
            data_done_q <= data_ok;
         end else begin
            cmd_done_q  <= 1'b0;
            data_done_q <= 1'b0;
         end
      end
   end

   // Array contents need no reset: the valid bits gate every use.
   always_ff @(posedge clk) begin
      if (rd_fill) begin
         data_q[idx] <= bus.mem_resp_data;
         tag_q[idx]  <= rtag;
      end else if (st_merge) begin
         data_q[idx] <= merged_line;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (cap) state_d = S_LOOKUP;
         S_LOOKUP: begin
            if (is_store)  state_d = S_WR_REQ;
            else if (hit)  state_d = cap ? S_LOOKUP : S_IDLE;
            else           state_d = S_RD_REQ;
         end
         S_RD_REQ:  if (cmd_fire) state_d = S_RD_WAIT;
         S_RD_WAIT: if (resp_match) state_d = S_IDLE;
         S_WR_REQ:  if (cmd_ok && data_ok) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.stall         = 1'b0;
      bus.cpu_resp_dout = '0;
      req_valid         = 1'b0;
      data_valid        = 1'b0;
      bus.mem_req_rw    = 1'b0;
      case (state_q)
         S_IDLE:    bus.cpu_resp_dout = resp_pend_q ? resp_word_q : 32'h0;
         S_LOOKUP: begin
            if (is_load && hit) bus.cpu_resp_dout = cur_line[{offset, 5'b0} +: 32];
            else                bus.stall = 1'b1;
         end
         S_RD_REQ: begin
            bus.stall = 1'b1;
            req_valid = 1'b1;
         end
         S_RD_WAIT: bus.stall = 1'b1;
         S_WR_REQ: begin
            bus.stall      = 1'b1;
            bus.mem_req_rw = 1'b1;
            req_valid      = !cmd_done_q;
            data_valid     = !data_done_q;
         end
         default: ;
      endcase
   end

   assign bus.mem_req_valid      = req_valid;
   assign bus.mem_req_data_valid = data_valid;
   assign bus.mem_req_addr       = addr_q[29:2];
   assign bus.mem_req_tag        = tag_cnt_q;
   assign bus.mem_req_data_bits  = {4{din_q}};
   assign bus.mem_req_data_mask  = 16'({12'h000, we_q} << {offset, 2'b00});
   assign state_o                = state_q;
endmodule

// File: tb/tb_dcache_responder.sv
// Randomised bench for dcache_responder: a word-level memory model predicts load data,
// line presence and expected memory commands; CPU and memory monitors check the DUT.
module tb_dcache_responder;
   localparam int LINES = 64;
   localparam int TAG_W = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] state_dbg;
   int         n_cmp = 0;
   int         n_bad = 0;

   dcache_responder_if #(.TAG_W(TAG_W)) bus ();

   dcache_responder #(.LINES(LINES), .TAG_W(TAG_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .state_o (state_dbg)
   );

   always #5 clk = ~clk;

   // Reference model: flat word memory, per-index cached line, next read tag.
   logic [31:0]      ref_mem [logic [29:0]];
   logic [31:0]      ram [logic [29:0]];
   bit               ref_valid [LINES];
   logic [27:0]      ref_line [LINES];
   logic [TAG_W-1:0] ref_tag;

   logic [33:0]  exp_q[$];      // {predicted hit, is load, load data}
   logic [32:0]  exp_cmd_q[$];  // {rw, tag, line}
   logic [171:0] exp_wd_q[$];   // {line, mask, data}
   int           outstanding = 0;

   bit hold_resp = 1'b0;
   bit wr_delay_mode = 1'b0;
   bit force_stale = 1'b0;
   int rd_seen = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bound_expired(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   function automatic logic [31:0] init_word(logic [29:0] wa);
      return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
   endfunction

   function automatic logic [31:0] ref_rd(logic [29:0] wa);
      return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
   endfunction

   function automatic logic [31:0] ram_rd(logic [29:0] wa);
      return ram.exists(wa) ? ram[wa] : init_word(wa);
   endfunction

   function automatic logic [127:0] ram_line(logic [27:0] line);
      return {ram_rd({line, 2'd3}), ram_rd({line, 2'd2}), ram_rd({line, 2'd1}), ram_rd({line, 2'd0})};
   endfunction

   // Called in the cycle the DUT is about to capture a request.
   function automatic void model_capture(logic [31:0] a, logic [3:0] we, logic [31:0] din);
      logic [27:0]  line;
      int           idx;
      logic         hit;
      logic [31:0]  w;
      logic [15:0]  mask;
      line = a[31:4];
      idx  = int'(line) % LINES;
      hit  = ref_valid[idx] && (ref_line[idx] == line);
      if (we != 4'b0000) begin
         mask = '0;
         w    = ref_rd(a[31:2]);
         for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
               mask[4 * int'(a[3:2]) + b] = 1'b1;
               w[b*8 +: 8] = din[b*8 +: 8];
            end
         end
         ref_mem[a[31:2]] = w;
         exp_cmd_q.push_back({1'b1, TAG_W'(0), line});
         exp_wd_q.push_back({line, mask, din, din, din, din});
         exp_q.push_back({1'b0, 1'b0, 32'h0});
      end else begin
         if (!hit) begin
            exp_cmd_q.push_back({1'b0, ref_tag, line});
            ref_tag        = ref_tag + TAG_W'(1);
            ref_valid[idx] = 1'b1;
            ref_line[idx]  = line;
         end
         exp_q.push_back({hit, 1'b1, ref_rd(a[31:2])});
      end
   endfunction

   task automatic issue(input logic [31:0] a, input logic re, input logic [3:0] we, input logic [31:0] din);
      bit got = 1'b0;
      bus.cpu_req_addr = a;
      bus.cpu_req_re   = re;
      bus.cpu_req_we   = we;
      bus.cpu_req_din  = din;
      for (int t = 0; t < 300 && !got; t++) begin
         @(negedge clk);
         if (!bus.stall) begin
            got = 1'b1;
            model_capture(a, we, din);
         end
         @(posedge clk);
         #1;
      end
      if (got) outstanding++;
      else bound_expired("capture_timeout");
      bus.cpu_req_re = 1'b0;
      bus.cpu_req_we = 4'b0000;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int t = 0; t < 400 && !done; t++) begin
         if (outstanding == 0) done = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!done) bound_expired("drain_timeout");
   endtask

   // CPU-side monitor: the first stall-free cycle after a capture carries its response.
   initial begin : cpu_monitor
      logic [33:0] e;
      forever begin
         @(negedge clk);
         if (!reset && outstanding > 0 && exp_q.size() > 0) begin
            e = exp_q[0];
            if (!bus.stall) begin
               void'(exp_q.pop_front());
               outstanding--;
               if (e[32]) check("load_dout", bus.cpu_resp_dout, e[31:0]);
            end else if (e[33]) begin
               check("hit_stall", bus.stall, 1'b0);
            end
         end
      end
   end

   // Memory emulator: random readiness, delayed responses, optional stale-tag response first.
   initial begin : mem_model
      logic             resp_pend, stale_pend, wr_cmd_seen;
      int               resp_wait, since_cmd;
      logic [TAG_W-1:0] resp_tag;
      logic [27:0]      resp_line;
      logic [32:0]      c;
      logic [171:0]     w;
      resp_pend = 1'b0; stale_pend = 1'b0; wr_cmd_seen = 1'b0;
      resp_wait = 0; since_cmd = 0; resp_tag = '0; resp_line = '0;
      bus.mem_req_ready = 1'b0; bus.mem_req_data_ready = 1'b0;
      bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0; bus.mem_resp_tag = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_req_valid && bus.mem_req_ready) begin
            if (exp_cmd_q.size() == 0) begin
               check("spurious_cmd", bus.mem_req_valid, 1'b0);
            end else begin
               c = exp_cmd_q.pop_front();
               check("cmd_rw", bus.mem_req_rw, c[32]);
               check("cmd_addr", bus.mem_req_addr, c[27:0]);
               check("cmd_stall", bus.stall, 1'b1);
               if (!c[32]) begin
                  check("cmd_tag", bus.mem_req_tag, c[31:28]);
                  resp_pend  = 1'b1;
                  resp_tag   = bus.mem_req_tag;
                  resp_line  = c[27:0];
                  resp_wait  = $urandom_range(0, 3);
                  stale_pend = force_stale || ($urandom_range(0, 2) == 0);
                  rd_seen++;
               end else begin
                  wr_cmd_seen = 1'b1;
                  since_cmd   = 0;
               end
            end
         end
         if (bus.mem_req_data_valid && bus.mem_req_data_ready) begin
            if (exp_wd_q.size() == 0) begin
               check("spurious_wdata", bus.mem_req_data_valid, 1'b0);
            end else begin
               w = exp_wd_q.pop_front();
               check("wr_mask", bus.mem_req_data_mask, w[143:128]);
               check("wr_data", bus.mem_req_data_bits, w[127:0]);
               check("wr_stall", bus.stall, 1'b1);
               for (int k = 0; k < 16; k++) begin
                  if (bus.mem_req_data_mask[k]) begin
                     logic [29:0] wa;
                     logic [31:0] v;
                     wa = {w[171:144], 2'(k / 4)};
                     v  = ram_rd(wa);
                     v[(k % 4) * 8 +: 8] = bus.mem_req_data_bits[k*8 +: 8];
                     ram[wa] = v;
                  end
               end
               wr_cmd_seen = 1'b0;
            end
         end
         @(posedge clk);
         #1;
         since_cmd++;
         bus.mem_req_ready      = wr_delay_mode ? 1'b1 : 1'($urandom_range(0, 1));
         bus.mem_req_data_ready = wr_delay_mode ? (wr_cmd_seen && since_cmd >= 3)
                                                : 1'($urandom_range(0, 1));
         bus.mem_resp_valid = 1'b0;
         bus.mem_resp_tag   = '0;
         bus.mem_resp_data  = '0;
         if (resp_pend && !hold_resp) begin
            if (resp_wait > 0) begin
               resp_wait--;
            end else if (stale_pend) begin
               bus.mem_resp_valid = 1'b1;
               bus.mem_resp_tag   = resp_tag ^ TAG_W'(1);
               bus.mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
               stale_pend = 1'b0;
               resp_wait  = 1;
            end else begin
               bus.mem_resp_valid = 1'b1;
               bus.mem_resp_tag   = resp_tag;
               bus.mem_resp_data  = ram_line(resp_line);
               resp_pend = 1'b0;
            end
         end
      end
   end

   initial begin : stimulus
      logic [27:0] pool [8];
      logic [31:0] a;
      logic [3:0]  we;
      int          start;
      pool[0] = 28'h000_0000; pool[1] = 28'h000_0040; pool[2] = 28'h000_003F; pool[3] = 28'hFFF_FFFF;
      pool[4] = 28'hFFF_FFC0; pool[5] = 28'h000_0100; pool[6] = 28'h000_0101; pool[7] = 28'h123_4567;
      ref_mem[30'h400] = 32'hAAAA_AAAA; ref_mem[30'h401] = 32'hBBBB_BBBB;
      ref_mem[30'h402] = 32'hCCCC_CCCC; ref_mem[30'h403] = 32'hDDDD_DDDD;
      ram[30'h400] = 32'hAAAA_AAAA; ram[30'h401] = 32'hBBBB_BBBB;
      ram[30'h402] = 32'hCCCC_CCCC; ram[30'h403] = 32'hDDDD_DDDD;
      for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
      ref_tag = '0;
      bus.cpu_req_addr = '0; bus.cpu_req_re = 1'b0; bus.cpu_req_we = 4'b0000; bus.cpu_req_din = '0;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_stall", bus.stall, 1'b0);
      check("rst_req_valid", bus.mem_req_valid, 1'b0);
      check("rst_data_valid", bus.mem_req_data_valid, 1'b0);
      check("rst_dout", bus.cpu_resp_dout, 32'h0);
      check("rst_state", state_dbg, 3'd0);
      @(posedge clk);
      #1;

      // Miss fill, then back-to-back hits, store hit merge, store miss without allocate.
      issue(32'h0000_1004, 1'b1, 4'b0000, 32'h0);
      wait_idle();
      issue(32'h0000_1004, 1'b1, 4'b0000, 32'h0);
      issue(32'h0000_1008, 1'b1, 4'b0000, 32'h0);
      wait_idle();
      issue(32'h0000_1008, 1'b0, 4'b0011, 32'h0000_1234);
      issue(32'h0000_1008, 1'b1, 4'b0000, 32'h0);
      wait_idle();
      issue(32'h0000_2000, 1'b0, 4'b1111, 32'h5566_7788);
      force_stale = 1'b1;
      issue(32'h0000_2000, 1'b1, 4'b0000, 32'h0);
      wait_idle();
      force_stale = 1'b0;

      // Write data accepted well after the command; store carrying re as well.
      wr_delay_mode = 1'b1;
      issue(32'h0000_200C, 1'b1, 4'b1100, 32'hABCD_0000);
      wait_idle();
      wr_delay_mode = 1'b0;
      issue(32'h0000_200C, 1'b1, 4'b0000, 32'h0);
      wait_idle();

      // Reset while a fill is outstanding; the late response must be ignored.
      hold_resp = 1'b1;
      start = rd_seen;
      issue(32'h0000_3004, 1'b1, 4'b0000, 32'h0);
      for (int t = 0; t < 200 && rd_seen == start; t++) @(posedge clk);
      if (rd_seen == start) bound_expired("rd_cmd_timeout");
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      exp_q.delete();
      exp_cmd_q.delete();
      exp_wd_q.delete();
      outstanding = 0;
      for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
      ref_tag = '0;
      @(negedge clk);
      check("mid_rst_stall", bus.stall, 1'b0);
      check("mid_rst_req_valid", bus.mem_req_valid, 1'b0);
      check("mid_rst_data_valid", bus.mem_req_data_valid, 1'b0);
      check("mid_rst_dout", bus.cpu_resp_dout, 32'h0);
      @(posedge clk);
      #1 hold_resp = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      issue(32'h0000_1004, 1'b1, 4'b0000, 32'h0);
      wait_idle();

      // Random mix over a small, conflicting address pool including wrap-around lines.
      for (int n = 0; n < 250; n++) begin
         a = {pool[$urandom_range(0, 7)], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 9) < 6) begin
            issue(a, 1'b1, 4'b0000, 32'h0);
         end else begin
            we = 4'($urandom_range(1, 15));
            issue(a, 1'($urandom_range(0, 1)), we, $urandom);
         end
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      wait_idle();
      repeat (5) @(posedge clk);
      check("exp_q_left", exp_q.size(), 0);
      check("cmd_q_left", exp_cmd_q.size(), 0);
      check("wd_q_left", exp_wd_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
